// File: rtl/pcie_packet_router_pkg.sv
// Shared types and header field layout for the PCIe packet router.
package pcie_packet_router_pkg;

    localparam int PCIE_DATA_W       = 512;
    localparam int PCIE_HDR_DEST_LSB = 0;
    localparam int PCIE_HDR_DEST_W   = 8;
    localparam int PCIE_HDR_LEN_LSB  = 8;
    localparam int PCIE_HDR_LEN_W    = 16;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } pcie_router_state_t;

    // Destination app index carried in a header word.
    function automatic logic [PCIE_HDR_DEST_W-1:0] hdr_dest(input logic [PCIE_DATA_W-1:0] w);
        return w[PCIE_HDR_DEST_LSB +: PCIE_HDR_DEST_W];
    endfunction

    // Payload word count carried in a header word.
    function automatic logic [PCIE_HDR_LEN_W-1:0] hdr_len(input logic [PCIE_DATA_W-1:0] w);
        return w[PCIE_HDR_LEN_LSB +: PCIE_HDR_LEN_W];
    endfunction

endpackage

// File: rtl/pcie_packet_router_out_reg.sv
// One-entry output holding register shared by all app ports.
// A word is presented one-hot to its destination app and held until accepted;
// a new load may coincide with the firing of the current word.
module pcie_router_out_reg #(
    parameter int NUM_APPS = 4,
    parameter int DATA_W   = 512,
    parameter int DEST_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DEST_W-1:0]   dest_i,
    input  logic                last_i,
    input  logic [NUM_APPS-1:0] ready_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [NUM_APPS-1:0] valid_o,
    output logic                last_o,
    output logic                occupied_o,
    output logic                free_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [DEST_W-1:0] dest_q;
    logic              last_q;
    logic              fire;

    // Decode one-hot valid; ready on a port without valid has no effect.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            valid_o[i] = valid_q && (dest_q == DEST_W'(i));
        end
        fire   = |(valid_o & ready_i);
        free_o = !valid_q || fire;
    end

    // Holding register: load wins over fire so back-to-back words stream at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            dest_q  <= dest_i;
            last_q  <= last_i;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o     = data_q;
    assign last_o     = last_q;
    assign occupied_o = valid_q;

endmodule

// File: rtl/pcie_packet_router.sv
// Routes the unified PCIe packet stream (header + N payload words) to one of
// NUM_APPS inbound app ports; messages to nonexistent apps are consumed and dropped.
module pcie_packet_router
    import pcie_packet_router_pkg::*;
#(
    parameter int NUM_APPS  = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PCIE_DATA_W-1:0] packet_in,
    input  logic                   packet_in_valid,
    output logic                   packet_in_grant,
    output logic [PCIE_DATA_W-1:0] app_data,
    output logic [NUM_APPS-1:0]    app_valid,
    input  logic [NUM_APPS-1:0]    app_ready,
    output logic                   app_last,
    output logic [CNT_WIDTH-1:0]   msg_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   busy
);

    localparam logic [PCIE_HDR_DEST_W-1:0] NUM_APPS_D = PCIE_HDR_DEST_W'(NUM_APPS);
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = CNT_WIDTH'(1);

    pcie_router_state_t          state_q, state_d;
    logic [PCIE_HDR_LEN_W-1:0]   remaining_q, remaining_d;
    logic [PCIE_HDR_DEST_W-1:0]  cur_dest_q, cur_dest_d;
    logic [CNT_WIDTH-1:0]        msg_count_q, drop_count_q;
    logic                        grant, load, msg_inc, drop_inc;
    logic                        out_free, out_occupied;
    logic [PCIE_HDR_DEST_W-1:0]  in_dest;
    logic [PCIE_HDR_LEN_W-1:0]   in_len;

    assign in_dest = hdr_dest(packet_in);
    assign in_len  = hdr_len(packet_in);

    // Next-state, grant and output-register load decisions.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_dest_d  = cur_dest_q;
        grant       = 1'b0;
        load        = 1'b0;
        msg_inc     = 1'b0;
        drop_inc    = 1'b0;
        unique case (state_q)
            HDR: begin
                grant = packet_in_valid;
                if (grant && (in_len != '0)) begin
                    remaining_d = in_len;
                    if (in_dest >= NUM_APPS_D) begin
                        drop_inc = 1'b1;
                        state_d  = DROP;
                    end else begin
                        cur_dest_d = in_dest;
                        state_d    = PAY;
                    end
                end
            end
            PAY: begin
                grant = packet_in_valid && out_free;
                if (grant) begin
                    load        = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 16'd1) begin
                        msg_inc = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            DROP: begin
                grant = packet_in_valid;
                if (grant) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 16'd1) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    // FSM state, message bookkeeping and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HDR;
            remaining_q  <= '0;
            cur_dest_q   <= '0;
            msg_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_dest_q  <= cur_dest_d;
            if (msg_inc)  msg_count_q  <= msg_count_q + CNT_ONE;
            if (drop_inc) drop_count_q <= drop_count_q + CNT_ONE;
        end
    end

    pcie_router_out_reg #(
        .NUM_APPS (NUM_APPS),
        .DATA_W   (PCIE_DATA_W),
        .DEST_W   (PCIE_HDR_DEST_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .data_i     (packet_in),
        .dest_i     (cur_dest_q),
        .last_i     (remaining_q == 16'd1),
        .ready_i    (app_ready),
        .data_o     (app_data),
        .valid_o    (app_valid),
        .last_o     (app_last),
        .occupied_o (out_occupied),
        .free_o     (out_free)
    );

    // Upstream must never dequeue while the router is held in reset.
    assign packet_in_grant = grant && rst_n;
    assign msg_count       = msg_count_q;
    assign drop_count      = drop_count_q;
    assign busy            = (state_q != HDR) || out_occupied;

endmodule

// File: tb/tb_pcie_packet_router.sv
module tb_pcie_packet_router;

    localparam int NA = 4;
    localparam int CW = 32;

    typedef struct packed {
        logic [NA-1:0] vld;
        logic [511:0]  data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [511:0]  packet_in = '0;
    logic          packet_in_valid = 1'b0;
    logic          packet_in_grant;
    logic [511:0]  app_data;
    logic [NA-1:0] app_valid;
    logic [NA-1:0] app_ready = '1;
    logic          app_last;
    logic [CW-1:0] msg_count, drop_count;
    logic          busy;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    pcie_packet_router #(.NUM_APPS(NA), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid), .packet_in_grant(packet_in_grant),
        .app_data(app_data), .app_valid(app_valid), .app_ready(app_ready), .app_last(app_last),
        .msg_count(msg_count), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk_hdr(input logic [7:0] dest, input logic [15:0] len);
        return {{15{32'hDEADBEEF}}, 8'hFF, len, dest};
    endfunction

    function automatic logic [511:0] mk_word(input int id);
        return {16{32'hC0DE0000 + 32'(id)}};
    endfunction

    function automatic logic [NA-1:0] onehot(input int d);
        logic [NA-1:0] v;
        v = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    // Present a word and hold it until granted; returns the stall cycles seen.
    task automatic send_word(input logic [511:0] w, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        packet_in = w;
        packet_in_valid = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (packet_in_grant) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL grant_timeout: word %h never granted", w[31:0]);
        end
        @(posedge clk); #1;
        packet_in_valid = 1'b0;
    endtask

    task automatic push_exp(input int dest, input int id, input logic last);
        exp_t e;
        e.vld = onehot(dest);
        e.data = mk_word(id);
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", name, sb.size(), busy);
        end
    endtask

    // Scoreboard: every accepted app word must match the oldest expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ((app_valid & app_ready) != '0)) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: valid=%b data=%h, required no word", app_valid, app_data[31:0]);
                end else begin
                    e = sb.pop_front();
                    if (app_valid !== e.vld || app_data !== e.data || app_last !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_word: valid=%b data=%h last=%b, required valid=%b data=%h last=%b",
                                 app_valid, app_data[31:0], app_last, e.vld, e.data[31:0], e.last);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        packet_in = mk_hdr(8'd1, 16'd1);
        packet_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (packet_in_grant !== 1'b0) begin
            n_fail++; $display("FAIL reset_grant: got %b, required 0", packet_in_grant);
        end
        n_cmp++;
        if (app_valid !== '0 || app_last !== 1'b0 || app_data !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h busy=%b, required all 0", app_valid, app_last, app_data[31:0], busy);
        end
        n_cmp++;
        if (msg_count !== '0 || drop_count !== '0) begin
            n_fail++; $display("FAIL reset_counters: msg=%0d drop=%0d, required 0/0", msg_count, drop_count);
        end
        packet_in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int w, tot;
        app_ready = '1;
        tot = 0;
        send_word(mk_hdr(8'd2, 16'd3), w); tot += w;
        for (int i = 0; i < 3; i++) begin
            push_exp(2, 10 + i, i == 2);
            send_word(mk_word(10 + i), w); tot += w;
        end
        n_cmp++;
        if (tot !== 0) begin
            n_fail++; $display("FAIL basic_grant: stall cycles=%0d, required 0", tot);
        end
        wait_drain("basic");
        n_cmp++;
        if (msg_count !== 32'd1) begin
            n_fail++; $display("FAIL basic_msg_count: got %0d, required 1", msg_count);
        end
    endtask

    task automatic test_stall();
        int w;
        app_ready = '1;
        send_word(mk_hdr(8'd2, 16'd3), w);
        push_exp(2, 20, 1'b0); send_word(mk_word(20), w);
        push_exp(2, 21, 1'b0); send_word(mk_word(21), w);
        app_ready = 4'b1011;
        packet_in = mk_word(22);
        packet_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (packet_in_grant !== 1'b0 || app_valid !== 4'b0100 || app_data !== mk_word(21)) begin
                n_fail++;
                $display("FAIL stall_hold: grant=%b valid=%b data=%h, required grant=0 valid=0100 data=%h",
                         packet_in_grant, app_valid, app_data[31:0], mk_word(21) & 512'hFFFFFFFF);
            end
            @(posedge clk); #1;
        end
        app_ready = '1;
        push_exp(2, 22, 1'b1); send_word(mk_word(22), w);
        wait_drain("stall");
        n_cmp++;
        if (msg_count !== 32'd2) begin
            n_fail++; $display("FAIL stall_msg_count: got %0d, required 2", msg_count);
        end
    endtask

    task automatic test_drop();
        int w, tot;
        tot = 0;
        app_ready = '1;
        send_word(mk_hdr(8'd7, 16'd2), w); tot += w;
        for (int i = 0; i < 2; i++) begin
            send_word(mk_word(30 + i), w); tot += w;
            n_cmp++;
            if (app_valid !== '0) begin
                n_fail++; $display("FAIL drop_valid: got %b, required 0000", app_valid);
            end
        end
        n_cmp++;
        if (tot !== 0 || drop_count !== 32'd1) begin
            n_fail++; $display("FAIL drop_count: stalls=%0d drop=%0d, required 0/1", tot, drop_count);
        end
        send_word(mk_hdr(8'd0, 16'd1), w);
        push_exp(0, 32, 1'b1); send_word(mk_word(32), w);
        wait_drain("drop");
        n_cmp++;
        if (msg_count !== 32'd3 || drop_count !== 32'd1) begin
            n_fail++; $display("FAIL drop_after: msg=%0d drop=%0d, required 3/1", msg_count, drop_count);
        end
    endtask

    task automatic test_len0();
        int w;
        app_ready = '1;
        send_word(mk_hdr(8'd1, 16'd0), w);
        n_cmp++;
        if (busy !== 1'b0 || msg_count !== 32'd3 || drop_count !== 32'd1) begin
            n_fail++; $display("FAIL len0_silent: busy=%b msg=%0d drop=%0d, required 0/3/1", busy, msg_count, drop_count);
        end
        send_word(mk_hdr(8'd1, 16'd1), w);
        push_exp(1, 40, 1'b1); send_word(mk_word(40), w);
        wait_drain("len0");
        n_cmp++;
        if (msg_count !== 32'd4) begin
            n_fail++; $display("FAIL len0_msg_count: got %0d, required 4", msg_count);
        end
    endtask

    task automatic test_back_to_back();
        int w, w3;
        app_ready = 4'b1110;
        send_word(mk_hdr(8'd0, 16'd1), w);
        push_exp(0, 50, 1'b1); send_word(mk_word(50), w);
        send_word(mk_hdr(8'd3, 16'd1), w);
        n_cmp++;
        if (w !== 0 || app_valid !== 4'b0001) begin
            n_fail++; $display("FAIL b2b_hdr: stalls=%0d valid=%b, required 0/0001", w, app_valid);
        end
        push_exp(3, 51, 1'b1);
        fork
            send_word(mk_word(51), w3);
            begin
                repeat (2) @(posedge clk);
                #1 app_ready = '1;
            end
        join
        n_cmp++;
        if (w3 < 1) begin
            n_fail++; $display("FAIL b2b_wait: stalls=%0d, required >=1", w3);
        end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid();
        int w;
        app_ready = '1;
        send_word(mk_hdr(8'd1, 16'd8), w);
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 60 + i, 1'b0);
            send_word(mk_word(60 + i), w);
        end
        packet_in = mk_word(63);
        packet_in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (app_valid !== '0 || app_data !== '0 || msg_count !== '0 || drop_count !== '0 || busy !== 1'b0 || packet_in_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b data=%h msg=%0d drop=%0d busy=%b grant=%b, required all 0",
                     app_valid, app_data[31:0], msg_count, drop_count, busy, packet_in_grant);
        end
        sb.delete();
        packet_in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(mk_hdr(8'd2, 16'd1), w);
        push_exp(2, 64, 1'b1); send_word(mk_word(64), w);
        wait_drain("reset_mid");
        n_cmp++;
        if (msg_count !== 32'd1 || drop_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_after: msg=%0d drop=%0d, required 1/0", msg_count, drop_count);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: pending=%0d, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
